// File: rtl/bp_pkt_coalesce.sv
// Byte-pipe coalescer: gathers upstream bytes and releases them downstream as one burst
// when full, after an idle timeout, or on an explicit flush.
module bp_pkt_coalesce #(
  parameter int unsigned MAX_PKT = 8,
  parameter int unsigned TIMEOUT = 1000
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_cg,
  input  logic                       i_flush,
  input  logic [7:0]                 i_bp_data,
  input  logic                       i_bp_valid,
  output logic                       o_bp_ready,
  output logic [7:0]                 o_bp_data,
  output logic                       o_bp_valid,
  input  logic                       i_bp_ready,
  output logic [$clog2(MAX_PKT):0]   o_nBytes
);

  localparam int unsigned PW = $clog2(MAX_PKT);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FullCnt  = CW'(MAX_PKT);
  localparam logic [CW-1:0] OneCnt   = CW'(1);
  localparam logic [15:0]   IdleLast = 16'(TIMEOUT - 1);

  typedef enum logic [0:0] {StFill, StDrain} state_e;

  state_e          state_q, state_d;
  logic [7:0]      mem_q [MAX_PKT];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [15:0]     idle_q, idle_d;
  logic            accept;
  logic            drain_hs;

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    idle_d     = idle_q;
    o_bp_ready = 1'b0;
    o_bp_valid = 1'b0;
    o_bp_data  = 8'h00;
    accept     = 1'b0;
    drain_hs   = 1'b0;

    unique case (state_q)
      StFill: begin
        o_bp_ready = i_cg && !i_rst && (count_q < FullCnt);
        accept     = i_bp_valid && o_bp_ready;
        if (accept) begin
          wr_ptr_d = wr_ptr_q + PW'(1);
          count_d  = count_q + OneCnt;
          idle_d   = '0;
        end else if (count_q != '0) begin
          if (idle_q != '1) idle_d = idle_q + 16'd1;
        end else begin
          idle_d = '0;
        end

        if (accept && (count_q == FullCnt - OneCnt)) begin
          state_d = StDrain;
        end else if (!accept && (count_q != '0) && (idle_q == IdleLast)) begin
          state_d = StDrain;
        end else if (i_flush && ((count_q != '0) || accept)) begin
          state_d = StDrain;
        end
      end

      StDrain: begin
        o_bp_valid = i_cg;
        o_bp_data  = mem_q[rd_ptr_q];
        drain_hs   = i_cg && i_bp_ready;
        if (drain_hs) begin
          rd_ptr_d = rd_ptr_q + PW'(1);
          count_d  = count_q - OneCnt;
          if (count_q == OneCnt) begin
            state_d = StFill;
            idle_d  = '0;
          end
        end
      end
    endcase
  end

  // i_cg low holds every register; reset still takes priority.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= StFill;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      idle_q   <= '0;
    end else if (i_cg) begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      idle_q   <= idle_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (accept) mem_q[wr_ptr_q] <= i_bp_data;
  end

  assign o_nBytes = count_q;

endmodule
